term_printer: RTL

Parametrised terminal print engine for the lab UART console. Two kinds of request arrive here: fixed-text message commands from the command/control logic, and numeric reports from N result sources (ALU, CPU, benchmark, …). The block arbitrates between them and formats reports as ASCII hex lines. It streams bytes one at a time to the UART transmitter over a valid/ready handshake.

---
 rtl/printer_pkg.sv | 33 +++
 rtl/printer_str_rom.sv | 60 ++++++
 rtl/term_printer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/printer_pkg.sv
// Shared types, ASCII constants and helpers for the terminal print engine.
package printer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MSG_RD,
        ST_MSG_TX,
        ST_RPT_TX,
        ST_DONE
    } state_t;

    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_NUL = 8'h00;
    localparam logic [7:0] CH_R   = 8'h52;
    localparam logic [7:0] CH_EQ  = 8'h3D;

    localparam int MSG_NONE    = 0;
    localparam int MSG_INTRO   = 1;
    localparam int MSG_BENCH   = 2;
    localparam int MSG_ALU     = 3;
    localparam int MSG_CPU     = 4;
    localparam int MSG_INVALID = 5;
    localparam int MSG_REPORT  = 6;

    function automatic logic [7:0] hex2ascii(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/printer_str_rom.sv
// Message string ROM, registered read. Returns the addressed byte and its
// successor so the caller can spot the terminating NUL one byte early.
module printer_str_rom
    import printer_pkg::*;
#(
    parameter int MSG_W   = 3,
    parameter int MAX_LEN = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [MSG_W+$clog2(MAX_LEN)-1:0] addr,
    output logic [7:0]                   rdata,
    output logic [7:0]                   rnext
);

    localparam int IDX_W = $clog2(MAX_LEN);

    logic [MSG_W-1:0] cmd;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_n;

    assign cmd   = addr[MSG_W+IDX_W-1:IDX_W];
    assign idx   = addr[IDX_W-1:0];
    assign idx_n = idx + IDX_W'(1);

    // Strings are held right-justified in a 16-character field.
    function automatic logic [7:0] str_byte(input logic [MSG_W-1:0] c,
                                            input logic [IDX_W-1:0] i);
        logic [127:0] s;
        int           n;
        int           j;
        s = '0;
        n = 0;
        j = int'(i);
        case (int'(c))
            MSG_INTRO:   begin s = 128'("HELLO");   n = 5; end
            MSG_BENCH:   begin s = 128'("BENCH");   n = 5; end
            MSG_ALU:     begin s = 128'("ALU");     n = 3; end
            MSG_CPU:     begin s = 128'("CPU");     n = 3; end
            MSG_INVALID: begin s = 128'("INVALID"); n = 7; end
            MSG_REPORT:  begin s = 128'("REPORT");  n = 6; end
            default:     begin s = '0;              n = 0; end
        endcase
        if (j < n)
            str_byte = s[8*(n-1-j) +: 8];
        else
            str_byte = CH_NUL;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= CH_NUL;
            rnext <= CH_NUL;
        end else begin
            rdata <= str_byte(cmd, idx);
            rnext <= str_byte(cmd, idx_n);
        end
    end

endmodule

// File: rtl/term_printer.sv
// Terminal print engine: arbitrates fixed messages and numeric reports and
// streams them as ASCII bytes over a valid/ready link to the UART.
//
// state     | meaning
// ST_IDLE   | arbitrate; message beats reports, lowest source index wins
// ST_MSG_RD | first ROM read of the selected string in flight
// ST_MSG_TX | present string bytes until NUL or MAX_LEN
// ST_RPT_TX | present "R<i>=<hex>" CR LF from the latched payload
// ST_DONE   | one-cycle completion pulse
module term_printer
    import printer_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 32,
    parameter int MSG_W   = 3,
    parameter int MAX_LEN = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MSG_W-1:0]          msg_cmd,
    input  logic                      msg_valid,
    output logic                      msg_ready,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ack,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      busy,
    output logic                      done
);

    localparam int NIB     = DATA_W / 4;
    localparam int RPT_LEN = 5 + NIB;
    localparam int K_W     = $clog2(RPT_LEN);
    localparam int IDX_W   = $clog2(MAX_LEN);
    localparam int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    state_t              state_q, state_d;
    logic [MSG_W-1:0]    cmd_q;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [K_W-1:0]      k_q;
    logic [SRC_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   payload_q;
    logic [7:0]          rom_data, rom_next;
    logic [7:0]          rpt_byte;
    logic                any_src;
    logic                msg_acc, rpt_acc, tx_fire;
    logic                rpt_last, msg_last;
    int                  kk, nib_pos;

    printer_str_rom #(
        .MSG_W   (MSG_W),
        .MAX_LEN (MAX_LEN)
    ) u_rom (
        .clk   (clk),
        .rst   (rst),
        .addr  ({cmd_q, idx_d}),
        .rdata (rom_data),
        .rnext (rom_next)
    );

    always_comb begin
        any_src = 1'b0;
        sel_d   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_valid[i]) begin
                any_src = 1'b1;
                sel_d   = SRC_W'(i);
            end
        end
    end

    // Acceptance is masked during reset so no handshake leaks out while rst is high.
    assign msg_acc  = (state_q == ST_IDLE) && msg_valid && !rst;
    assign rpt_acc  = (state_q == ST_IDLE) && !msg_valid && any_src && !rst;
    assign tx_fire  = tx_valid && tx_ready;
    assign rpt_last = (k_q == K_W'(RPT_LEN - 1));
    assign msg_last = (rom_next == CH_NUL) || (idx_q == IDX_W'(MAX_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (msg_acc)
                    state_d = (msg_cmd == '0) ? ST_DONE : ST_MSG_RD;
                else if (rpt_acc)
                    state_d = ST_RPT_TX;
            end
            ST_MSG_RD: state_d = ST_MSG_TX;
            ST_MSG_TX: begin
                if (rom_data == CH_NUL)
                    state_d = ST_DONE;
                else if (tx_fire && msg_last)
                    state_d = ST_DONE;
            end
            ST_RPT_TX: begin
                if (tx_fire && rpt_last)
                    state_d = ST_DONE;
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // The ROM is addressed with the next index so a stalled byte is simply re-read.
    always_comb begin
        idx_d = idx_q;
        if (state_q == ST_IDLE)
            idx_d = '0;
        else if (state_q == ST_MSG_TX && tx_fire)
            idx_d = idx_q + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q     <= '0;
            idx_q     <= '0;
            k_q       <= '0;
            sel_q     <= '0;
            payload_q <= '0;
        end else begin
            idx_q <= idx_d;
            if (msg_acc)
                cmd_q <= msg_cmd;
            if (rpt_acc) begin
                sel_q     <= sel_d;
                payload_q <= src_data[int'(sel_d)*DATA_W +: DATA_W];
                k_q       <= '0;
            end else if (state_q == ST_RPT_TX && tx_fire) begin
                k_q <= k_q + K_W'(1);
            end
        end
    end

    always_comb begin
        kk       = int'(k_q);
        nib_pos  = 0;
        rpt_byte = CH_LF;
        if (kk == 0)
            rpt_byte = CH_R;
        else if (kk == 1)
            rpt_byte = hex2ascii(4'(sel_q));
        else if (kk == 2)
            rpt_byte = CH_EQ;
        else if (kk < 3 + NIB) begin
            nib_pos  = NIB - 1 - (kk - 3);
            rpt_byte = hex2ascii(payload_q[4*nib_pos +: 4]);
        end else if (kk == 3 + NIB)
            rpt_byte = CH_CR;
    end

    always_comb begin
        msg_ready = msg_acc;
        src_ack   = rpt_acc ? (NUM_SRC'(1) << sel_d) : '0;
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        case (state_q)
            ST_MSG_TX: begin
                tx_valid = (rom_data != CH_NUL);
                tx_data  = rom_data;
            end
            ST_RPT_TX: begin
                tx_valid = 1'b1;
                tx_data  = rpt_byte;
            end
            default: ;
        endcase
    end

endmodule
